// File: rtl/mm_bus_ctrl.sv
// CPU-side bus controller: takes one CPU request, decodes it through the memory map,
// runs a single strobed bus access with an ack timeout, and returns data or an error pulse.
module mm_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [31:0] dec_addr,
    input  logic [7:0]  dec_mod,
    input  logic [31:0] dec_eff_addr,
    output logic [10:0] bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        ACCESS,
        DONE,
        ERROR
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        op_write;
    logic [7:0]  mod_q;
    logic [31:0] eff_q;
    logic [15:0] wait_cnt;
    logic        err_q;

    logic        cpu_req;
    logic        decode_ok;
    logic        in_access;

    // Only populated module codes map to a select line; anything else decodes to zero.
    function automatic logic [10:0] module_onehot(input logic [7:0] code);
        logic [10:0] sel;
        sel = '0;
        case (code)
            8'd0:    sel = 11'h001;
            8'd1:    sel = 11'h002;
            8'd2:    sel = 11'h004;
            8'd3:    sel = 11'h008;
            8'd4:    sel = 11'h010;
            8'd8:    sel = 11'h100;
            8'd9:    sel = 11'h200;
            8'd10:   sel = 11'h400;
            default: sel = '0;
        endcase
        return sel;
    endfunction

    always_comb begin
        cpu_req   = cpu_we | cpu_re;
        in_access = (state == ACCESS);
        // Code 0 is ROM, so a write to it is rejected just like an unmapped code.
        decode_ok = (|module_onehot(dec_mod)) && !(op_write && (dec_mod == 8'd0));
    end

    always_comb begin
        cpu_stall = (state == IDLE) ? cpu_req : ((state == DECODE) || in_access);
        dec_addr  = (state == IDLE) ? cpu_addr : addr_q;
        cpu_err   = err_q;
        bus_sel   = in_access ? module_onehot(mod_q) : '0;
        bus_addr  = in_access ? eff_q : '0;
        bus_wdata = in_access ? data_q : '0;
        bus_we    = in_access && op_write;
        bus_re    = in_access && !op_write;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            op_write <= 1'b0;
            mod_q    <= '0;
            eff_q    <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            cpu_dout <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q   <= cpu_addr;
                        data_q   <= cpu_din;
                        op_write <= cpu_we;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    mod_q <= dec_mod;
                    eff_q <= dec_eff_addr;
                    if (decode_ok) begin
                        wait_cnt <= '0;
                        state    <= ACCESS;
                    end else begin
                        err_q <= 1'b1;
                        state <= ERROR;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so a late ack on the final wait cycle still completes.
                    if (bus_ack) begin
                        if (!op_write) begin
                            cpu_dout <= bus_rdata;
                        end
                        state <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err_q <= 1'b1;
                        state <= ERROR;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_bus_ctrl.sv
// Bench for mm_bus_ctrl: table of single transactions checked through a scoreboard queue,
// plus hand sequences for DONE-cycle request handling and reset in the middle of an access.
module tb_mm_bus_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        cpu_err;
    logic [31:0] dec_addr;
    logic [7:0]  dec_mod;
    logic [31:0] dec_eff_addr;
    logic [10:0] bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] din;
        logic [7:0]  mod;
        logic [31:0] eff;
        int          ack_at;
        logic [31:0] rdata;
        logic        stray;
        logic [10:0] exp_sel;
        int          exp_we;
        int          exp_re;
        logic        exp_err;
        logic [31:0] exp_dout;
        int          exp_done;
    } vec_t;

    vec_t vecs[13];
    vec_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    mm_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cpu_we       (cpu_we),
        .cpu_re       (cpu_re),
        .cpu_dout     (cpu_dout),
        .cpu_stall    (cpu_stall),
        .cpu_err      (cpu_err),
        .dec_addr     (dec_addr),
        .dec_mod      (dec_mod),
        .dec_eff_addr (dec_eff_addr),
        .bus_sel      (bus_sel),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] din, input logic [7:0] mod, input logic [31:0] eff,
                                input int ack_at, input logic [31:0] rdata, input logic stray,
                                input logic [10:0] exp_sel, input int exp_we, input int exp_re,
                                input logic exp_err, input logic [31:0] exp_dout, input int exp_done);
        vec_t v;
        v.we = we;           v.re = re;           v.addr = addr;
        v.din = din;         v.mod = mod;         v.eff = eff;
        v.ack_at = ack_at;   v.rdata = rdata;     v.stray = stray;
        v.exp_sel = exp_sel; v.exp_we = exp_we;   v.exp_re = exp_re;
        v.exp_err = exp_err; v.exp_dout = exp_dout; v.exp_done = exp_done;
        return v;
    endfunction

    // Called at a falling edge with the controller idle; holds the request until stall drops.
    task automatic apply_stimulus(input int idx, input vec_t v);
        vec_t        exp;
        int          cycle;
        int          acc;
        int          we_cnt;
        int          re_cnt;
        int          bad;
        logic [10:0] seen_sel;
        logic        done;
        cycle = 0; acc = 0; we_cnt = 0; re_cnt = 0; bad = 0; seen_sel = '0; done = 1'b0;
        sb_q.push_back(v);
        cpu_we = v.we; cpu_re = v.re; cpu_addr = v.addr; cpu_din = v.din;
        dec_mod = v.mod; dec_eff_addr = v.eff; bus_rdata = v.rdata; bus_ack = v.stray;
        #1;
        check_output($sformatf("v%0d_stall_on_request", idx), 32'(cpu_stall), 32'd1);
        check_output($sformatf("v%0d_dec_addr_idle", idx), dec_addr, v.addr);
        while (!done && cycle < 40) begin
            @(negedge clk);
            cycle++;
            if (bus_sel != '0) begin
                acc++;
                seen_sel = seen_sel | bus_sel;
                if (bus_we) we_cnt++;
                if (bus_re) re_cnt++;
                if (bus_addr !== v.eff || bus_wdata !== v.din) bad++;
                bus_ack = (acc == v.ack_at);
            end else begin
                if (bus_we || bus_re || bus_addr != '0 || bus_wdata != '0) bad++;
                bus_ack = v.stray;
            end
            if (!cpu_stall) done = 1'b1;
        end
        exp = sb_q.pop_front();
        check_output($sformatf("v%0d_completion_seen", idx), 32'(done), 32'd1);
        check_output($sformatf("v%0d_done_cycle", idx), 32'(cycle), 32'(exp.exp_done));
        check_output($sformatf("v%0d_cpu_err", idx), 32'(cpu_err), 32'(exp.exp_err));
        check_output($sformatf("v%0d_cpu_dout", idx), cpu_dout, exp.exp_dout);
        check_output($sformatf("v%0d_bus_sel", idx), 32'(seen_sel), 32'(exp.exp_sel));
        check_output($sformatf("v%0d_we_cycles", idx), 32'(we_cnt), 32'(exp.exp_we));
        check_output($sformatf("v%0d_re_cycles", idx), 32'(re_cnt), 32'(exp.exp_re));
        check_output($sformatf("v%0d_bus_fields", idx), 32'(bad), 32'd0);
        cpu_we = 1'b0; cpu_re = 1'b0; bus_ack = 1'b0;
        @(negedge clk);
        check_output($sformatf("v%0d_err_after", idx), 32'(cpu_err), 32'd0);
        check_output($sformatf("v%0d_stall_after", idx), 32'(cpu_stall), 32'd0);
        check_output($sformatf("v%0d_sel_after", idx), 32'(bus_sel), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        //            we re addr          din           mod    eff           ack rdata         st sel      we re err dout          done
        vecs[0]  = mk(0, 1, 32'h10000040, 32'h00000000, 8'd1,  32'h00000040, 1, 32'hDEADBEEF, 0, 11'h002, 0, 1, 0, 32'hDEADBEEF, 3);
        vecs[1]  = mk(1, 0, 32'hF0200000, 32'h00000055, 8'd4,  32'h00200000, 3, 32'h00000000, 0, 11'h010, 3, 0, 0, 32'hDEADBEEF, 5);
        vecs[2]  = mk(1, 0, 32'h00000010, 32'h00000077, 8'd0,  32'h00000010, 1, 32'h00000000, 0, 11'h000, 0, 0, 1, 32'hDEADBEEF, 2);
        vecs[3]  = mk(0, 1, 32'hA0000100, 32'h00000000, 8'd9,  32'h00000100, 0, 32'h12345678, 0, 11'h200, 0, 4, 1, 32'hDEADBEEF, 6);
        vecs[4]  = mk(0, 1, 32'hA0000104, 32'h00000000, 8'd9,  32'h00000104, 4, 32'hCAFEF00D, 0, 11'h200, 0, 4, 0, 32'hCAFEF00D, 6);
        vecs[5]  = mk(1, 1, 32'h20000008, 32'hA5A5A5A5, 8'd2,  32'h00000008, 2, 32'h99999999, 0, 11'h004, 2, 0, 0, 32'hCAFEF00D, 4);
        vecs[6]  = mk(0, 1, 32'h50000000, 32'h00000000, 8'd5,  32'h00000000, 1, 32'h11111111, 0, 11'h000, 0, 0, 1, 32'hCAFEF00D, 2);
        vecs[7]  = mk(0, 1, 32'hFF000000, 32'h00000000, 8'hFF, 32'h00000000, 1, 32'h11111111, 0, 11'h000, 0, 0, 1, 32'hCAFEF00D, 2);
        vecs[8]  = mk(0, 1, 32'h00000020, 32'h00000000, 8'd0,  32'h00000020, 1, 32'h0BADC0DE, 0, 11'h001, 0, 1, 0, 32'h0BADC0DE, 3);
        vecs[9]  = mk(0, 1, 32'hB0000010, 32'h00000000, 8'd10, 32'h00000010, 2, 32'h11112222, 1, 11'h400, 0, 2, 0, 32'h11112222, 4);
        vecs[10] = mk(1, 0, 32'h80000004, 32'h13572468, 8'd8,  32'h00000004, 1, 32'h77777777, 0, 11'h100, 1, 0, 0, 32'h11112222, 3);
        vecs[11] = mk(0, 1, 32'h30000000, 32'h00000000, 8'd3,  32'h00000000, 1, 32'h0F0F0F0F, 0, 11'h008, 0, 1, 0, 32'h0F0F0F0F, 3);
        vecs[12] = mk(0, 1, 32'hB8000000, 32'h00000000, 8'd11, 32'h00000000, 1, 32'h22222222, 0, 11'h000, 0, 0, 1, 32'h0F0F0F0F, 2);

        rst = 1'b0;
        cpu_addr = 32'h12345678; cpu_din = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        dec_mod = '0; dec_eff_addr = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_cpu_dout", cpu_dout, 32'd0);
        check_output("reset_stall", 32'(cpu_stall), 32'd0);
        check_output("reset_err", 32'(cpu_err), 32'd0);
        check_output("reset_bus_sel", 32'(bus_sel), 32'd0);
        check_output("reset_strobes", 32'({bus_we, bus_re}), 32'd0);
        check_output("reset_dec_addr", dec_addr, 32'h12345678);

        // First request lands on the edge right after reset release.
        rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        $display("[TB] request held through DONE is taken only in the following IDLE cycle");
        cpu_re = 1'b1; cpu_addr = 32'h10000080; dec_mod = 8'd1; dec_eff_addr = 32'h00000080;
        bus_rdata = 32'h24682468; bus_ack = 1'b0;
        @(negedge clk);
        check_output("hold_decode_sel", 32'(bus_sel), 32'd0);
        @(negedge clk);
        check_output("hold_access1_sel", 32'(bus_sel), 32'h002);
        bus_ack = 1'b1;
        @(negedge clk);
        check_output("hold_done_stall", 32'(cpu_stall), 32'd0);
        check_output("hold_done_dout", cpu_dout, 32'h24682468);
        bus_ack = 1'b0; cpu_addr = 32'h10000090; dec_eff_addr = 32'h00000090; bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        check_output("hold_idle_stall", 32'(cpu_stall), 32'd1);
        check_output("hold_idle_dec_addr", dec_addr, 32'h10000090);
        @(negedge clk);
        check_output("hold_decode2_sel", 32'(bus_sel), 32'd0);
        @(negedge clk);
        check_output("hold_access2_sel", 32'(bus_sel), 32'h002);
        check_output("hold_access2_addr", bus_addr, 32'h00000090);
        bus_ack = 1'b1;
        @(negedge clk);
        check_output("hold_done2_dout", cpu_dout, 32'h55AA55AA);
        cpu_re = 1'b0; bus_ack = 1'b0;
        @(negedge clk);

        $display("[TB] reset asserted in the middle of an access");
        cpu_re = 1'b1; cpu_addr = 32'h90000000; dec_mod = 8'd9; dec_eff_addr = 32'h00000044;
        @(negedge clk);
        @(negedge clk);
        check_output("abort_re_before", 32'(bus_re), 32'd1);
        cpu_re = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_output("abort_sel_now", 32'(bus_sel), 32'd0);
        check_output("abort_re_now", 32'(bus_re), 32'd0);
        check_output("abort_addr_now", bus_addr, 32'd0);
        check_output("abort_stall_now", 32'(cpu_stall), 32'd0);
        check_output("abort_dout_now", cpu_dout, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_sel != '0 || cpu_stall || cpu_err) bad++;
        end
        check_output("abort_no_replay", 32'(bad), 32'd0);

        apply_stimulus(13, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mm_bus_ctrl.md
MM_BUS_CTRL -- requirements
Module: mm_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, ack wait limit in cycles (1..65535).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-low reset.
- cpu_addr  in  32  word-aligned request address.
- cpu_din  in  32  write data.
- cpu_we  in  1  write request.
- cpu_re  in  1  read request.
- cpu_dout  out  32  read data.
- cpu_stall  out  1  CPU must hold request.
- cpu_err  out  1  one-cycle error pulse.
- dec_addr  out  32  address driven to the memory-map decoder.
- dec_mod  in  8  decoder module code.
- dec_eff_addr  in  32  decoder effective address.
- bus_sel  out  11  one-hot module select; bit n = module code n.
- bus_addr  out  32  effective address to the module.
- bus_wdata  out  32  write data to the module.
- bus_we  out  1  write strobe.
- bus_re  out  1  read strobe.
- bus_rdata  in  32  shared read-data return.
- bus_ack  in  1  module completion.

Function
REQ-003 States: IDLE, DECODE, ACCESS, DONE, ERROR.
REQ-004 IDLE: cpu_we or cpu_re high -> latch cpu_addr, cpu_din and op (write wins if both high); next DECODE.
REQ-005 cpu_stall is combinationally high in IDLE while a request is present, and in DECODE and ACCESS; it is low in IDLE with no request, and in DONE and ERROR.
REQ-006 dec_addr drives the latched address in every state except IDLE, where it drives cpu_addr.
REQ-007 DECODE (1 cycle): register dec_mod and dec_eff_addr.
REQ-008 DECODE: valid codes are 0,1,2,3,4,8,9,10. Any other code, or a write to code 0 (ROM), goes to ERROR with no bus strobe.
REQ-009 DECODE otherwise: next ACCESS, load the wait counter with 0.
REQ-010 ACCESS: bus_sel[code]=1, bus_addr=registered eff_addr, bus_wdata=latched data, bus_we/bus_re per op. Outside ACCESS all bus outputs are 0.
REQ-011 ACCESS, bus_ack=1: register bus_rdata into cpu_dout on reads (cpu_dout unchanged on writes); next DONE.
REQ-012 ACCESS, bus_ack=0: increment the counter. Counter == TIMEOUT-1 -> next ERROR.
REQ-013 bus_ack and timeout in the same cycle: ack wins.
REQ-014 Minimum latency with immediate ack: request seen in IDLE at cycle 0 -> DECODE 1 -> ACCESS 2 -> DONE 3, with cpu_stall low at cycle 3.
REQ-015 DONE: one cycle; next IDLE. A request present in that cycle is not sampled; it is sampled in the following IDLE cycle.
REQ-016 ERROR: cpu_err=1 for exactly this cycle; cpu_dout unchanged; next IDLE.
REQ-017 bus_ack outside ACCESS is ignored.
REQ-018 Counter width is 16 bits and the counter never wraps.

Reset
REQ-019 On rst low, asynchronously: state=IDLE; cpu_dout, latched address/data, counter and registered decode = 0; bus_sel, bus_we, bus_re, cpu_err = 0.
REQ-020 Reset mid-ACCESS drops all strobes immediately. The aborted transaction is not replayed.
REQ-021 After rst rises, the first request is accepted on the next clock edge.

Verification
REQ-022 Read 0x10000040, dec_mod=1, eff 0x00000040, ack at first ACCESS cycle, rdata 0xDEADBEEF -> bus_sel=0x002 for 1 cycle; cpu_dout=0xDEADBEEF; stall cycles 0-2, low at 3.
REQ-023 Write 0xF0200000 data 0x55, mod=4, ack after 3 ACCESS cycles -> bus_sel=0x010, bus_we=1 for 3 cycles, bus_wdata=0x55, then DONE; cpu_err=0.
REQ-024 Write to mod 0 (address 0x00000010) -> no bus strobe; cpu_err pulses once at cycle 2; back to IDLE at cycle 3.
REQ-025 TIMEOUT=4, read of mod 9, no ack -> bus_re high exactly 4 cycles; then ERROR with cpu_err=1; cpu_dout unchanged.
REQ-026 bus_ack in the 4th ACCESS cycle with TIMEOUT=4 -> DONE, no error.
REQ-027 cpu_we and cpu_re both high -> write performed; rst low mid-ACCESS -> strobes 0 the same cycle, state IDLE.
